// File: rtl/branch_sequencer.sv
// branch_sequencer: NZCV flag register plus conditional-branch sequencer (evaluate, flush, PC load, acknowledge)
module branch_sequencer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flag_we,
  input  logic [3:0]            flags_in,
  input  logic                  br_req,
  input  logic [3:0]            br_cond,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  br_ack,
  output logic                  br_taken,
  input  logic                  pc_ready,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  flush,
  output logic                  stall,
  output logic [3:0]            flags
);
  typedef enum logic [2:0] {IDLE, EVAL, FLUSH, LOAD, DONE} state_t;
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            cond_q, cond_d, flags_q, flags_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic                  take_q, take_d;
  logic                  n, z, c, v, d;
  logic [15:0]           cond_tbl;
  always_comb begin
    {n, z, c, v} = flags_q;
    d = n ^ v;
    cond_tbl = {1'b0, 1'b1, z | d, ~z & ~d, d, ~d, ~c | z, c & ~z,
                ~v, v, ~n, n, ~c, c, ~z, z};
    flags_d = flag_we ? flags_in : flags_q;
    state_d = state_q;
    cnt_d = cnt_q;
    cond_d = cond_q;
    target_d = target_q;
    take_d = take_q;
    case (state_q)
      IDLE: begin
        state_d = br_req ? EVAL : IDLE;
        cond_d = br_req ? br_cond : cond_q;
        target_d = br_req ? br_target : target_q;
      end
      EVAL: begin
        take_d = cond_tbl[cond_q];
        state_d = !take_d ? DONE : (FLUSH_CYCLES == 0) ? LOAD : FLUSH;
        cnt_d = CW'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        state_d = (cnt_q == '0) ? LOAD : FLUSH;
        cnt_d = cnt_q - 1'b1;
      end
      LOAD: state_d = pc_ready ? DONE : LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cond_q <= '0;
      target_q <= '0;
      take_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cond_q <= cond_d;
      target_q <= target_d;
      take_q <= take_d;
      flags_q <= flags_d;
    end
  end
  assign stall = state_q != IDLE;
  assign flush = state_q == FLUSH;
  assign pc_load = state_q == LOAD;
  assign pc_next = pc_load ? target_q : '0;
  assign br_ack = state_q == DONE;
  assign br_taken = br_ack & take_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed self-checking bench for branch_sequencer
module tb_branch_sequencer;
  logic        clock, reset, flag_we, br_req, br_ack, br_taken, pc_ready, pc_load, flush, stall;
  logic [3:0]  flags_in, br_cond, flags;
  logic [31:0] br_target, pc_next;
  int errors = 0;
  int checks = 0;
  int lat;
  logic sf, sl, bo, tk;
  logic [31:0] pn;

  branch_sequencer #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .flag_we(flag_we), .flags_in(flags_in),
    .br_req(br_req), .br_cond(br_cond), .br_target(br_target),
    .br_ack(br_ack), .br_taken(br_taken), .pc_ready(pc_ready),
    .pc_load(pc_load), .pc_next(pc_next), .flush(flush), .stall(stall), .flags(flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Issue a request in the current cycle (cycle 0) and follow it to br_ack.
  task automatic run_req(input logic [3:0] cc, input logic [31:0] t,
                         output int l, output logic f_seen, output logic l_seen,
                         output logic both, output logic taken, output logic [31:0] nxt);
    br_req = 1'b1;
    br_cond = cc;
    br_target = t;
    l = 0;
    f_seen = 1'b0;
    l_seen = 1'b0;
    both = 1'b0;
    nxt = '0;
    do begin
      step();
      l++;
      flag_we = 1'b0;
      f_seen |= flush;
      l_seen |= pc_load;
      both |= flush & pc_load;
      if (pc_load) nxt = pc_next;
    end while (!br_ack && l < 40);
    taken = br_taken;
    br_req = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    flag_we = 1'b0;
    flags_in = '0;
    br_req = 1'b0;
    br_cond = '0;
    br_target = '0;
    pc_ready = 1'b1;
    step();
    step();
    chk("rst_outs", {31'd0, br_ack | br_taken | pc_load | flush | stall}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_stall", {31'd0, stall}, 32'd0);

    flags_in = 4'b0100;
    flag_we = 1'b1;
    step();
    flag_we = 1'b0;
    chk("t1_flags", {28'd0, flags}, 32'h4);
    run_req(4'h0, 32'h100, lat, sf, sl, bo, tk, pn);
    chk("t1_lat", lat, 5);
    chk("t1_taken", {31'd0, tk}, 32'd1);
    chk("t1_flush", {31'd0, sf}, 32'd1);
    chk("t1_load", {31'd0, sl}, 32'd1);
    chk("t1_pcnext", pn, 32'h100);
    chk("t1_excl", {31'd0, bo}, 32'd0);
    chk("t1_ack_clear", {31'd0, br_ack | br_taken | stall}, 32'd0);

    flags_in = 4'b0000;
    flag_we = 1'b1;
    step();
    flag_we = 1'b0;
    run_req(4'h0, 32'h200, lat, sf, sl, bo, tk, pn);
    chk("t2_lat", lat, 2);
    chk("t2_taken", {31'd0, tk}, 32'd0);
    chk("t2_noflush", {31'd0, sf | sl}, 32'd0);

    for (int f = 0; f < 16; f++) begin
      for (int cc = 0; cc < 16; cc++) begin
        flags_in = 4'(f);
        flag_we = 1'b1;
        step();
        flag_we = 1'b0;
        run_req(4'(cc), 32'h1000 + 32'(cc), lat, sf, sl, bo, tk, pn);
        chk($sformatf("t3_taken_f%0h_c%0h", f, cc), {31'd0, tk}, {31'd0, model(4'(cc), 4'(f))});
        chk($sformatf("t3_lat_f%0h_c%0h", f, cc), lat, model(4'(cc), 4'(f)) ? 5 : 2);
      end
    end

    flags_in = 4'b0000;
    flag_we = 1'b1;
    step();
    flags_in = 4'b0100;
    run_req(4'h0, 32'h300, lat, sf, sl, bo, tk, pn);
    chk("t4a_taken", {31'd0, tk}, 32'd1);
    chk("t4a_lat", lat, 5);

    flags_in = 4'b0000;
    flag_we = 1'b1;
    step();
    flag_we = 1'b0;
    br_req = 1'b1;
    br_cond = 4'h0;
    br_target = 32'h400;
    step();
    br_req = 1'b0;
    flags_in = 4'b0100;
    flag_we = 1'b1;
    step();
    flag_we = 1'b0;
    chk("t4b_ack", {31'd0, br_ack}, 32'd1);
    chk("t4b_taken", {31'd0, br_taken}, 32'd0);
    step();
    chk("t4b_flags", {28'd0, flags}, 32'h4);

    pc_ready = 1'b0;
    br_req = 1'b1;
    br_cond = 4'hE;
    br_target = 32'hDEADBEEF;
    step();
    br_req = 1'b0;
    br_target = 32'h0;
    step();
    chk("t5_flush_c2", {31'd0, flush}, 32'd1);
    step();
    chk("t5_flush_c3", {31'd0, flush}, 32'd1);
    for (int i = 4; i <= 7; i++) begin
      step();
      chk($sformatf("t5_load_c%0d", i), {30'd0, pc_load, flush}, 32'd2);
      chk($sformatf("t5_pcnext_c%0d", i), pc_next, 32'hDEADBEEF);
      if (i == 7) pc_ready = 1'b1;
    end
    step();
    chk("t5_ack_c8", {30'd0, br_ack, br_taken}, 32'd3);
    chk("t5_pcnext_off", pc_next, 32'd0);
    step();

    br_req = 1'b1;
    br_cond = 4'h0;
    br_target = 32'h500;
    step();
    br_req = 1'b0;
    step();
    chk("t6_in_flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_outs", {31'd0, br_ack | br_taken | pc_load | flush | stall}, 32'd0);
    chk("t6_pcnext", pc_next, 32'd0);
    chk("t6_flags", {28'd0, flags}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6_idle_%0d", i), {31'd0, stall | pc_load | flush | br_ack}, 32'd0);
    end
    run_req(4'hF, 32'h600, lat, sf, sl, bo, tk, pn);
    chk("t6_new_lat", lat, 2);
    chk("t6_new_taken", {31'd0, tk}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
